// File: rtl/ppm_demod.sv
// ppm_demod: pulse-position demodulator. Recovers the slot index of the pulse
// in each frame (frame aligned by frame_sync) and hands the decoded value,
// with missing/multi-pulse flags, to a one-entry valid/ready output register.
// Optional macro PPM_DEMOD_SYNC_EN adds a 2-flop synchronizer ahead of the
// sample register (pipeline depth 3 instead of 1).
module ppm_demod #(
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ppm_in,
  input  logic                  frame_sync,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  err_missing,
  output logic                  err_multi,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overflow,
  output logic                  locked
);

`ifdef PPM_DEMOD_SYNC_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  localparam logic [FRAME_BITS-1:0] SLOT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic [P-1:0]          ppm_q, sync_q;
  logic                  s_ppm, s_sync, prev, rise;
  logic [FRAME_BITS-1:0] slot, pos;
  logic [1:0]            cnt;

  logic                  active, first, frame_end;
  logic [FRAME_BITS-1:0] cur_slot, base_pos, nxt_pos;
  logic [1:0]            base_cnt, nxt_cnt;

  // Identical delay line for pulse and sync keeps their alignment intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ppm_q  <= '0;
      sync_q <= '0;
    end else begin
      ppm_q[0]  <= ppm_in;
      sync_q[0] <= frame_sync;
      for (int i = 1; i < P; i++) begin
        ppm_q[i]  <= ppm_q[i-1];
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_ppm  = ppm_q[P-1];
  assign s_sync = sync_q[P-1];
  assign rise   = s_ppm && !prev;

  // Previous sample for edge detect; deliberately not cleared at frame edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= s_ppm;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: only the first sync matters; RUN is left only by reset.
  always_comb begin
    state_nxt = state;
    if (state == IDLE && s_sync) state_nxt = RUN;
  end

  // FSM outputs.
  always_comb begin
    locked = (state == RUN);
  end

  // Slot tracking: a sync cycle is always slot 0 (first lock or resync), and
  // slot 0 starts a fresh frame, so any partial frame is simply discarded.
  always_comb begin
    active    = (state == RUN) || s_sync;
    cur_slot  = s_sync ? '0 : slot;
    first     = (cur_slot == '0);
    base_cnt  = first ? 2'd0 : cnt;
    base_pos  = first ? '0 : pos;
    nxt_cnt   = (rise && base_cnt != 2'd2) ? base_cnt + 2'd1 : base_cnt;
    nxt_pos   = (rise && base_cnt == 2'd0) ? cur_slot : base_pos;
    frame_end = active && (cur_slot == SLOT_MAX);
  end

  // Per-frame accumulators: slot counter, first-rise position, rise count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      pos  <= '0;
      cnt  <= 2'd0;
    end else if (active) begin
      slot <= cur_slot + FRAME_BITS'(1);
      pos  <= nxt_pos;
      cnt  <= nxt_cnt;
    end
  end

  // One-entry output register; a result arriving while the held one is
  // stalled is dropped and recorded in the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      err_missing <= 1'b0;
      err_multi   <= 1'b0;
      data_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else if (frame_end && (!data_valid || data_ready)) begin
      data_out    <= (nxt_cnt == 2'd0) ? '0 : nxt_pos;
      err_missing <= (nxt_cnt == 2'd0);
      err_multi   <= (nxt_cnt == 2'd2);
      data_valid  <= 1'b1;
    end else if (frame_end) begin
      overflow    <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid  <= 1'b0;
    end
  end

endmodule
